ahb_bram_ctrl: RTL and testbench

- AHB-Lite slave front end for the on-chip code/data block RAM of the Cortex-M0 system; sits directly upstream of the dual-port BRAM.
- Converts AHB address/data phases into the BRAM write port (addra/dina/wea, byte enables) and read port (addrb → doutb, 1-cycle registered read).
- Zero-wait-state for all legal transfers.
- Forwards a pending write to an immediately following read of the same word so read-after-write is coherent.

---
 rtl/ahb_bram_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_ahb_bram_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_bram_ctrl.sv
// ---------------------------------------------------------------------------
// ahb_bram_ctrl
//
// AHB-Lite slave front end for the Cortex-M0 code/data block RAM. Turns AHB
// address/data phases into the write port (addra/dina/wea) and the read port
// (addrb -> doutb, one-cycle registered read) of a dual-port BRAM. Every
// legal transfer completes with zero wait states.
//
// A write commits to the BRAM at the end of its data phase. A read issued in
// that same cycle to the same word therefore gets old data back from the
// BRAM. A one-entry forward buffer holds the last write, and its bytes are
// merged into HRDATA.
//
// Optional feature (macro AHB_BRAM_ERR_EN):
//   defined   - an oversized or misaligned transfer gets a two-cycle ERROR
//               response and does not touch the BRAM or the forward buffer.
//   undefined - HRESP is always OKAY and HREADYOUT is always 1. Misaligned
//               low address bits are ignored, and HSIZE > 2 acts as a word.
//
// Ports:
//   HCLK, HRESETn      clock (also clocks the BRAM), async active-low reset
//   HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY
//                      AHB-Lite slave inputs
//   HREADYOUT, HRDATA, HRESP
//                      AHB-Lite slave outputs
//   bram_addra, bram_dina, bram_wea
//                      BRAM write port (word address, data, byte enables)
//   bram_addrb, bram_doutb
//                      BRAM read port (word address, registered read data)
// ---------------------------------------------------------------------------
module ahb_bram_ctrl #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [31:0]           HRDATA,
  output logic                  HRESP,
  output logic [ADDR_WIDTH-1:0] bram_addra,
  output logic [31:0]           bram_dina,
  output logic [3:0]            bram_wea,
  output logic [ADDR_WIDTH-1:0] bram_addrb,
  input  logic [31:0]           bram_doutb
);

  // Byte lanes touched by a transfer. Misaligned low bits are absorbed here:
  // a halfword looks only at bit 1, and a word always uses all four lanes.
  function automatic logic [3:0] byte_mask(input logic [2:0] size,
                                           input logic [1:0] lo);
    case (size)
      3'd0:    byte_mask = 4'b0001 << lo;
      3'd1:    byte_mask = lo[1] ? 4'b1100 : 4'b0011;
      default: byte_mask = 4'b1111;
    endcase
  endfunction

  // Address bits above the window alias onto it.
  logic unused_haddr;
  assign unused_haddr = ^HADDR[31:ADDR_WIDTH+2];

  logic [ADDR_WIDTH-1:0] haddr_word;
  logic                  accept;
  logic                  illegal;
  logic                  accept_ok;

  assign haddr_word = HADDR[ADDR_WIDTH+1:2];
  assign accept     = HSEL & HREADY & HTRANS[1];
  assign accept_ok  = accept & ~illegal;
  assign bram_addrb = haddr_word;

  // -------------------------------------------------------------------------
  // Error response
  // -------------------------------------------------------------------------
`ifdef AHB_BRAM_ERR_EN
  typedef enum logic [1:0] {ST_OKAY, ST_ERR1, ST_ERR2} err_state_t;

  err_state_t state;
  logic       ready_q;
  logic       resp_q;

  assign illegal = (HSIZE > 3'd2) ||
                   ((HSIZE == 3'd1) && HADDR[0]) ||
                   ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));

  // A new transfer can be accepted in ST_ERR2, because HREADY is high there.
  // So an error can follow an error directly.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= ST_OKAY;
      ready_q <= 1'b1;
      resp_q  <= 1'b0;
    end else begin
      case (state)
        ST_ERR1: begin
          state   <= ST_ERR2;
          ready_q <= 1'b1;
          resp_q  <= 1'b1;
        end
        default: begin
          if (accept && illegal) begin
            state   <= ST_ERR1;
            ready_q <= 1'b0;
            resp_q  <= 1'b1;
          end else begin
            state   <= ST_OKAY;
            ready_q <= 1'b1;
            resp_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign HREADYOUT = ready_q;
  assign HRESP     = resp_q;
`else
  assign illegal   = 1'b0;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Data-phase registers
  // -------------------------------------------------------------------------
  logic                  dp_valid;
  logic                  dp_write;
  logic [ADDR_WIDTH-1:0] dp_addr;
  logic [3:0]            dp_mask;

  // NOTE: state registers use non-blocking assignments, so every always_ff
  // samples the pre-edge values no matter what order the blocks run in.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
      dp_mask  <= '0;
    end else begin
      dp_valid <= accept_ok;
      if (accept_ok) begin
        dp_write <= HWRITE;
        dp_addr  <= haddr_word;
        dp_mask  <= byte_mask(HSIZE, HADDR[1:0]);
      end
    end
  end

  logic wr_phase;
  logic rd_phase;

  assign wr_phase = dp_valid & dp_write;
  assign rd_phase = dp_valid & ~dp_write;

  // wea is decoded from registers that clear asynchronously, so a reset in
  // the middle of a write drops the write at once.
  assign bram_addra = dp_addr;
  assign bram_dina  = HWDATA;
  assign bram_wea   = wr_phase ? dp_mask : 4'b0000;

  // -------------------------------------------------------------------------
  // Forward buffer
  // -------------------------------------------------------------------------
  logic                  fb_valid;
  logic [ADDR_WIDTH-1:0] fb_addr;
  logic [31:0]           fb_data;
  logic [3:0]            fb_mask;

  // Capturing a finished write takes priority over invalidation. The read
  // that is accepted alongside a write's data phase is exactly the case that
  // needs the buffer.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fb_valid <= 1'b0;
      fb_addr  <= '0;
      fb_data  <= '0;
      fb_mask  <= '0;
    end else if (wr_phase) begin
      fb_valid <= 1'b1;
      fb_addr  <= dp_addr;
      fb_data  <= HWDATA;
      fb_mask  <= dp_mask;
    end else if (accept_ok && !(!HWRITE && (haddr_word == fb_addr))) begin
      fb_valid <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Read data
  // -------------------------------------------------------------------------
  logic fwd_hit;
  assign fwd_hit = fb_valid && (fb_addr == dp_addr);

  // NOTE: a combinational block assigns every output before any branch, so
  // no path leaves a value held and no latch is inferred.
  always_comb begin
    HRDATA = 32'h0;
    if (rd_phase) begin
      for (int b = 0; b < 4; b++) begin
        HRDATA[b*8 +: 8] = (fwd_hit && fb_mask[b]) ? fb_data[b*8 +: 8]
                                                   : bram_doutb[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ahb_bram_ctrl
//
// Directed bench for ahb_bram_ctrl. It includes a behavioural read-first BRAM
// model.
//
// Timing: inputs change 1 time unit after a rising edge, and outputs are
// sampled on the following falling edge. So each table row gives the inputs
// for one cycle together with the outputs expected in that same cycle. The
// outputs reflect the data phase of the previous row's address phase.
// ---------------------------------------------------------------------------
module tb_ahb_bram_ctrl;

  localparam int AW = 12;

  logic          hclk;
  logic          hresetn;
  logic          hsel;
  logic [31:0]   haddr;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic          hwrite;
  logic [31:0]   hwdata;
  logic          hready;
  logic          hreadyout;
  logic [31:0]   hrdata;
  logic          hresp;
  logic [AW-1:0] bram_addra;
  logic [31:0]   bram_dina;
  logic [3:0]    bram_wea;
  logic [AW-1:0] bram_addrb;
  logic [31:0]   bram_doutb;

  int checks   = 0;
  int failures = 0;

  // Single slave on the bus, so the bus-level ready is this slave's ready.
  assign hready = hreadyout;

  ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .HCLK       (hclk),
    .HRESETn    (hresetn),
    .HSEL       (hsel),
    .HADDR      (haddr),
    .HTRANS     (htrans),
    .HSIZE      (hsize),
    .HWRITE     (hwrite),
    .HWDATA     (hwdata),
    .HREADY     (hready),
    .HREADYOUT  (hreadyout),
    .HRDATA     (hrdata),
    .HRESP      (hresp),
    .bram_addra (bram_addra),
    .bram_dina  (bram_dina),
    .bram_wea   (bram_wea),
    .bram_addrb (bram_addrb),
    .bram_doutb (bram_doutb)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Behavioural dual-port BRAM with a read-first registered read port.
  logic [31:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    bram_doutb = 32'h0;
  end
  always @(posedge hclk) begin
    for (int b = 0; b < 4; b++)
      if (bram_wea[b]) mem[bram_addra][b*8 +: 8] <= bram_dina[b*8 +: 8];
    bram_doutb <= mem[bram_addrb];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic [1:0] trans,
                       input logic wr, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    hsel   = sel;
    htrans = trans;
    hwrite = wr;
    hsize  = size;
    haddr  = addr;
    hwdata = wdata;
  endtask

  // One bus cycle: drive after the rising edge, return at the falling edge.
  task automatic cycle(input logic sel, input logic [1:0] trans,
                       input logic wr, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge hclk);
    #1;
    drive(sel, trans, wr, size, addr, wdata);
    @(negedge hclk);
  endtask

  typedef struct {
    logic          sel;
    logic [1:0]    trans;
    logic          wr;
    logic [2:0]    size;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [3:0]    exp_wea;
    logic [AW-1:0] exp_addra;
    logic [31:0]   exp_rdata;
  } vec_t;

  function automatic vec_t v(input logic sel, input logic [1:0] trans,
                             input logic wr, input logic [2:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] exp_wea,
                             input logic [AW-1:0] exp_addra,
                             input logic [31:0] exp_rdata);
    vec_t r;
    r.sel = sel; r.trans = trans; r.wr = wr; r.size = size;
    r.addr = addr; r.wdata = wdata;
    r.exp_wea = exp_wea; r.exp_addra = exp_addra; r.exp_rdata = exp_rdata;
    return r;
  endfunction

  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] ID = 2'b00;

  vec_t vecs [0:18];

  initial begin
    // Rows: sel, trans, write, size, addr, wdata, exp wea, exp addra, exp rdata
    vecs[0]  = v(1, NS, 1, 2, 32'h100,  32'h0,        4'h0, 12'h000, 32'h0);
    vecs[1]  = v(1, ID, 0, 2, 32'h0,    32'hDEADBEEF, 4'hF, 12'h040, 32'h0);
    vecs[2]  = v(1, NS, 0, 2, 32'h100,  32'h0,        4'h0, 12'h000, 32'h0);
    vecs[3]  = v(1, ID, 0, 2, 32'h0,    32'h0,        4'h0, 12'h000, 32'hDEADBEEF);
    vecs[4]  = v(1, NS, 1, 2, 32'h104,  32'h0,        4'h0, 12'h000, 32'h0);
    vecs[5]  = v(1, NS, 1, 0, 32'h105,  32'h11223344, 4'hF, 12'h041, 32'h0);
    vecs[6]  = v(1, NS, 0, 2, 32'h104,  32'h0000AA00, 4'h2, 12'h041, 32'h0);
    vecs[7]  = v(1, ID, 0, 2, 32'h0,    32'h0,        4'h0, 12'h000, 32'h1122AA44);
    vecs[8]  = v(1, NS, 1, 2, 32'h200,  32'h0,        4'h0, 12'h000, 32'h0);
    vecs[9]  = v(1, NS, 0, 2, 32'h200,  32'h55667788, 4'hF, 12'h080, 32'h0);
    vecs[10] = v(1, NS, 1, 1, 32'h202,  32'h0,        4'h0, 12'h000, 32'h55667788);
    vecs[11] = v(1, NS, 0, 2, 32'h200,  32'hBEEF0000, 4'hC, 12'h080, 32'h0);
    vecs[12] = v(1, ID, 0, 2, 32'h0,    32'h0,        4'h0, 12'h000, 32'hBEEF7788);
    vecs[13] = v(1, NS, 1, 2, 32'h300,  32'h0,        4'h0, 12'h000, 32'h0);
    vecs[14] = v(0, NS, 1, 2, 32'h300,  32'h12345678, 4'hF, 12'h0C0, 32'h0);
    vecs[15] = v(1, ID, 1, 2, 32'h300,  32'hFFFFFFFF, 4'h0, 12'h000, 32'h0);
    vecs[16] = v(1, NS, 0, 2, 32'h300,  32'hFFFFFFFF, 4'h0, 12'h000, 32'h0);
    vecs[17] = v(1, NS, 0, 2, 32'h4100, 32'h0,        4'h0, 12'h000, 32'h12345678);
    vecs[18] = v(1, ID, 0, 2, 32'h0,    32'h0,        4'h0, 12'h000, 32'hDEADBEEF);

    // Reset state.
    hresetn = 1'b0;
    drive(0, ID, 0, 0, 32'h0, 32'h0);
    repeat (3) @(posedge hclk);
    #1;
    check("reset_hreadyout", {31'h0, hreadyout}, 32'h1);
    check("reset_hresp",     {31'h0, hresp},     32'h0);
    check("reset_hrdata",    hrdata,             32'h0);
    check("reset_wea",       {28'h0, bram_wea},  32'h0);
    @(negedge hclk);
    hresetn = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 19; i++) begin
      @(posedge hclk);
      #1;
      drive(vecs[i].sel, vecs[i].trans, vecs[i].wr, vecs[i].size,
            vecs[i].addr, vecs[i].wdata);
      @(negedge hclk);
      check($sformatf("vec%0d_wea", i), {28'h0, bram_wea},
            {28'h0, vecs[i].exp_wea});
      if (vecs[i].exp_wea != 4'h0)
        check($sformatf("vec%0d_addra", i), {20'h0, bram_addra},
              {20'h0, vecs[i].exp_addra});
      check($sformatf("vec%0d_addrb", i), {20'h0, bram_addrb},
            {20'h0, vecs[i].addr[AW+1:2]});
      check($sformatf("vec%0d_hrdata", i), hrdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_hreadyout", i), {31'h0, hreadyout}, 32'h1);
      check($sformatf("vec%0d_hresp", i), {31'h0, hresp}, 32'h0);
    end

    // Reset in the middle of a write data phase: the write is dropped.
    cycle(1, NS, 1, 2, 32'h400, 32'h0);
    cycle(1, ID, 0, 2, 32'h0,   32'h0BADC0DE);
    cycle(1, NS, 1, 2, 32'h400, 32'h0);
    cycle(1, ID, 0, 2, 32'h0,   32'hCAFEF00D);
    check("rst_mid_wea_before", {28'h0, bram_wea}, 32'hF);
    #2;
    hresetn = 1'b0;
    #1;
    check("rst_mid_wea_now",  {28'h0, bram_wea},  32'h0);
    check("rst_mid_hready",   {31'h0, hreadyout}, 32'h1);
    check("rst_mid_hresp",    {31'h0, hresp},     32'h0);
    check("rst_mid_hrdata",   hrdata,             32'h0);
    drive(0, ID, 0, 0, 32'h0, 32'h0);
    @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    cycle(1, NS, 0, 2, 32'h400, 32'h0);
    cycle(1, ID, 0, 2, 32'h0,   32'h0);
    check("rst_mid_mem_kept", hrdata, 32'h0BADC0DE);

    // Misaligned word read at 0x102.
    cycle(1, NS, 0, 2, 32'h102, 32'h0);
`ifdef AHB_BRAM_ERR_EN
    cycle(1, ID, 0, 2, 32'h0, 32'h0);
    check("err1_hreadyout", {31'h0, hreadyout}, 32'h0);
    check("err1_hresp",     {31'h0, hresp},     32'h1);
    cycle(1, NS, 0, 2, 32'h100, 32'h0);
    check("err2_hreadyout", {31'h0, hreadyout}, 32'h1);
    check("err2_hresp",     {31'h0, hresp},     32'h1);
    cycle(1, ID, 0, 2, 32'h0, 32'h0);
    check("after_err_rdata",  hrdata,             32'hDEADBEEF);
    check("after_err_hresp",  {31'h0, hresp},     32'h0);
    check("after_err_hready", {31'h0, hreadyout}, 32'h1);
`else
    cycle(1, NS, 0, 2, 32'h100, 32'h0);
    check("misaligned_rdata",  hrdata,             32'hDEADBEEF);
    check("misaligned_hresp",  {31'h0, hresp},     32'h0);
    check("misaligned_hready", {31'h0, hreadyout}, 32'h1);
    cycle(1, ID, 0, 2, 32'h0, 32'h0);
    check("aligned_rdata", hrdata, 32'hDEADBEEF);
`endif

    cycle(0, ID, 0, 0, 32'h0, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
